// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target byte engine and future bus monitors.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    // The target counts as busy only once its own address has been matched.
    function automatic logic state_busy(input state_t st);
        logic b;
        case (st)
            ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK: b = 1'b1;
            default:                                          b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with history stage; registered edge and START/STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0] metastability stage, [1] synchronized, [2] history
    logic [2:0] scl_pipe_r;
    logic [2:0] sda_pipe_r;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;

    // Pipes reset to the idle-high bus level so reset release creates no edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pipe_r <= 3'b111;
            sda_pipe_r <= 3'b111;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            scl_pipe_r <= {scl_pipe_r[1:0], scl_in};
            sda_pipe_r <= {sda_pipe_r[1:0], sda_in};
            scl_rise_r <= scl_pipe_r[1] & ~scl_pipe_r[2];
            scl_fall_r <= ~scl_pipe_r[1] & scl_pipe_r[2];
            start_r    <= scl_pipe_r[1] & scl_pipe_r[2] & ~sda_pipe_r[1] & sda_pipe_r[2];
            stop_r     <= scl_pipe_r[1] & scl_pipe_r[2] & sda_pipe_r[1] & ~sda_pipe_r[2];
        end
    end

    // Line levels are taken from the history stage so they align with the detect pulses.
    assign scl       = scl_pipe_r[2];
    assign sda       = sda_pipe_r[2];
    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_target.sv
// I2C target byte engine: address match, ACK generation, byte receive and transmit.
// No clock stretching; SDA is only ever pulled low or released.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR = 7'h42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL_in,
    input  logic              SDA_in,
    output logic              SDA_out,
    output logic              SDA_oen,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_byte,
    output logic              tx_req,
    output logic              rw,
    output logic              busy,
    output logic              nack
);

    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_det_s;
    logic stop_det_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (SCL_in),
        .sda_in    (SDA_in),
        .scl       (scl_s),
        .sda       (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    state_t              state_r,     state_s;
    logic [2:0]          bit_cnt_r,   bit_cnt_s;
    logic [BYTE_W-1:0]   shift_r,     shift_s;
    logic                tx_loaded_r, tx_loaded_s;
    logic [BYTE_W-1:0]   rx_byte_r,   rx_byte_s;
    logic                rx_valid_r,  rx_valid_s;
    logic                tx_req_r,    tx_req_s;
    logic                nack_r,      nack_s;
    logic                rw_r,        rw_s;
    logic                busy_r,      busy_s;
    logic                sda_oen_r,   sda_oen_s;
    logic [BYTE_W-1:0]   shift_in_s;

    assign shift_in_s = {shift_r[BYTE_W-2:0], sda_s};

    // Next-state, shift/count and output decode for the byte engine.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        tx_loaded_s = tx_loaded_r;
        rx_byte_s   = rx_byte_r;
        rx_valid_s  = 1'b0;
        tx_req_s    = 1'b0;
        nack_s      = 1'b0;
        rw_s        = rw_r;
        sda_oen_s   = sda_oen_r;

        if (stop_det_s) begin
            state_s     = ST_IDLE;
            sda_oen_s   = 1'b1;
            tx_loaded_s = 1'b0;
        end else if (start_det_s) begin
            state_s     = ST_ADDR;
            bit_cnt_s   = 3'd0;
            sda_oen_s   = 1'b1;
            tx_loaded_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_oen_s = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_s   = shift_in_s;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r != 3'd7) begin
                            state_s = ST_ADDR;
                        end else if (shift_in_s[BYTE_W-1:1] == ADDR) begin
                            rw_s    = shift_in_s[0];
                            state_s = ST_ADDR_ACK;
                        end else begin
                            state_s = ST_WAIT_STOP;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    tx_req_s = scl_rise_s & rw_r;
                    if (!scl_fall_s) begin
                        state_s = ST_ADDR_ACK;
                    end else if (sda_oen_r) begin
                        sda_oen_s = 1'b0;
                    end else if (rw_r) begin
                        // The fall that ends the ACK clock already has to present data bit 7.
                        shift_s     = {tx_byte[BYTE_W-2:0], 1'b0};
                        sda_oen_s   = tx_byte[BYTE_W-1];
                        bit_cnt_s   = 3'd1;
                        tx_loaded_s = 1'b1;
                        state_s     = ST_TX;
                    end else begin
                        sda_oen_s = 1'b1;
                        bit_cnt_s = 3'd0;
                        state_s   = ST_RX;
                    end
                end
                ST_RX: begin
                    if (scl_rise_s) begin
                        shift_s   = shift_in_s;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            rx_byte_s  = shift_in_s;
                            rx_valid_s = 1'b1;
                            state_s    = ST_RX_ACK;
                        end else begin
                            state_s = ST_RX;
                        end
                    end else begin
                        state_s = ST_RX;
                    end
                end
                ST_RX_ACK: begin
                    if (!scl_fall_s) begin
                        state_s = ST_RX_ACK;
                    end else if (sda_oen_r) begin
                        sda_oen_s = 1'b0;
                    end else begin
                        sda_oen_s = 1'b1;
                        bit_cnt_s = 3'd0;
                        state_s   = ST_RX;
                    end
                end
                ST_TX: begin
                    // Load fall drives bit 7, seven more falls drive 6..0, the ninth releases.
                    if (!scl_fall_s) begin
                        state_s = ST_TX;
                    end else if (!tx_loaded_r) begin
                        shift_s     = {tx_byte[BYTE_W-2:0], 1'b0};
                        sda_oen_s   = tx_byte[BYTE_W-1];
                        bit_cnt_s   = 3'd1;
                        tx_loaded_s = 1'b1;
                    end else if (bit_cnt_r == 3'd0) begin
                        sda_oen_s   = 1'b1;
                        tx_loaded_s = 1'b0;
                        state_s     = ST_TX_ACK;
                    end else begin
                        sda_oen_s = shift_r[BYTE_W-1];
                        shift_s   = {shift_r[BYTE_W-2:0], 1'b0};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_TX_ACK: begin
                    sda_oen_s = 1'b1;
                    if (!(scl_rise_s && scl_s)) begin
                        state_s = ST_TX_ACK;
                    end else if (!sda_s) begin
                        tx_req_s = 1'b1;
                        state_s  = ST_TX;
                    end else begin
                        nack_s  = 1'b1;
                        state_s = ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oen_s = 1'b1;
                end
                default: begin
                    state_s   = ST_IDLE;
                    sda_oen_s = 1'b1;
                end
            endcase
        end

        busy_s = state_busy(state_s);
    end

    // State and output registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            tx_loaded_r <= 1'b0;
            rx_byte_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            tx_req_r    <= 1'b0;
            nack_r      <= 1'b0;
            rw_r        <= 1'b0;
            busy_r      <= 1'b0;
            sda_oen_r   <= 1'b1;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            tx_loaded_r <= tx_loaded_s;
            rx_byte_r   <= rx_byte_s;
            rx_valid_r  <= rx_valid_s;
            tx_req_r    <= tx_req_s;
            nack_r      <= nack_s;
            rw_r        <= rw_s;
            busy_r      <= busy_s;
            sda_oen_r   <= sda_oen_s;
        end
    end

    assign SDA_out  = 1'b0;
    assign SDA_oen  = sda_oen_r;
    assign rx_byte  = rx_byte_r;
    assign rx_valid = rx_valid_r;
    assign tx_req   = tx_req_r;
    assign rw       = rw_r;
    assign busy     = busy_r;
    assign nack     = nack_r;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged bus initiator, vector table, hand sequences and random transfers.
module tb_i2c_target;

    localparam int QCLK = 8;  // clk cycles per quarter SCL period

    typedef struct {
        logic [7:0]      ab;      // address byte incl. R/W
        int              n;       // data bytes
        logic [3:0][7:0] d;       // written bytes, or bytes supplied on tx_req
        logic            e_ack;
        int              e_rx;
        int              e_txr;
        int              e_nack;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_out;
    logic       sda_oen;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte = 8'hFF;
    logic       tx_req;
    logic       rw;
    logic       busy;
    logic       nack;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         txr_cnt = 0;
    int         nack_cnt = 0;
    int         oen_low_cnt = 0;
    vec_t       vecs[5];

    assign sda_bus = m_sda & (sda_oen | sda_out);

    always #5 clk = ~clk;

    i2c_target dut (
        .clk      (clk),
        .rst      (rst),
        .SCL_in   (m_scl),
        .SDA_in   (sda_bus),
        .SDA_out  (sda_out),
        .SDA_oen  (sda_oen),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy),
        .nack     (nack)
    );

    // Local client: collects received bytes, answers tx_req from a queue, counts events.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) rx_q.push_back(rx_byte);
            if (tx_req) begin
                txr_cnt++;
                tx_byte = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
            end
            if (nack) nack_cnt++;
            if (!sda_oen) oen_low_cnt++;
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not end within 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (QCLK) @(negedge clk);
    endtask

    task automatic bus_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            wait_q();
            m_scl = 1'b1;
            wait_q();
        end
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b1;
        wait_q();
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        m_sda = b;
        if (glitch) begin
            repeat (3) @(negedge clk);
            m_sda = ~b;
            @(negedge clk);
            m_sda = b;
            repeat (QCLK - 4) @(negedge clk);
        end else begin
            wait_q();
        end
        m_scl = 1'b1;
        wait_q();
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        b = sda_bus;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i], i == gbit);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            b[i] = x;
        end
        write_bit(~mack, 1'b0);
    endtask

    task automatic clear_events();
        rx_q.delete();
        tx_q.delete();
        txr_cnt = 0;
        nack_cnt = 0;
        oen_low_cnt = 0;
    endtask

    task automatic run_txn(input string nm, input vec_t v);
        logic       a;
        logic [7:0] b;
        clear_events();
        if (v.ab[0]) for (int i = 0; i < v.n; i++) tx_q.push_back(v.d[i]);
        bus_start();
        write_byte(v.ab, -1, a);
        check({nm, "/addr_ack"}, 32'(a), 32'(v.e_ack));
        check({nm, "/busy"}, 32'(busy), 32'(v.e_ack));
        if (v.e_ack) check({nm, "/rw"}, 32'(rw), 32'(v.ab[0]));
        for (int i = 0; i < v.n; i++) begin
            if (v.ab[0]) begin
                read_byte(b, i < v.n - 1);
                check($sformatf("%s/rd%0d", nm, i), 32'(b), 32'(v.e_ack ? v.d[i] : 8'hFF));
            end else begin
                write_byte(v.d[i], -1, a);
                check($sformatf("%s/wr_ack%0d", nm, i), 32'(a), 32'(v.e_ack));
            end
        end
        bus_stop();
        repeat (6) @(negedge clk);
        check({nm, "/busy_after_stop"}, 32'(busy), 32'(1'b0));
        check({nm, "/rx_count"}, rx_q.size(), v.e_rx);
        for (int i = 0; i < v.e_rx && i < rx_q.size(); i++)
            check($sformatf("%s/rx%0d", nm, i), 32'(rx_q[i]), 32'(v.d[i]));
        check({nm, "/tx_req_count"}, txr_cnt, v.e_txr);
        check({nm, "/nack_count"}, nack_cnt, v.e_nack);
        if (!v.e_ack) check({nm, "/sda_never_driven"}, oen_low_cnt, 0);
    endtask

    // Reference model: what a transfer should produce, from the bus rules alone.
    function automatic vec_t model(input logic [7:0] ab, input int n, input logic [3:0][7:0] d);
        vec_t v;
        v.ab     = ab;
        v.n      = n;
        v.d      = d;
        v.e_ack  = (ab[7:1] == 7'h42);
        v.e_rx   = (v.e_ack && !ab[0]) ? n : 0;
        v.e_txr  = (v.e_ack && ab[0]) ? n : 0;
        v.e_nack = (v.e_ack && ab[0]) ? 1 : 0;
        return v;
    endfunction

    initial begin
        logic       a;
        logic [7:0] b;
        logic [7:0] ab;
        logic [6:0] a7;
        logic [3:0][7:0] rd;
        int         k;
        int         n;

        vecs[0] = '{8'h84, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 1'b1, 2, 0, 0};
        vecs[1] = '{8'h86, 1, {8'h00, 8'h00, 8'h00, 8'h55}, 1'b0, 0, 0, 0};
        vecs[2] = '{8'h85, 2, {8'h00, 8'h00, 8'hC3, 8'h5A}, 1'b1, 0, 2, 1};
        vecs[3] = '{8'h84, 4, {8'h80, 8'h01, 8'hFF, 8'h00}, 1'b1, 4, 0, 0};
        vecs[4] = '{8'h87, 1, {8'h00, 8'h00, 8'h00, 8'h77}, 1'b0, 0, 0, 0};

        repeat (4) @(negedge clk);
        check("rst/sda_oen", 32'(sda_oen), 32'(1'b1));
        check("rst/sda_out", 32'(sda_out), 32'(1'b0));
        check("rst/rx_byte", 32'(rx_byte), 32'(8'h00));
        check("rst/rx_valid", 32'(rx_valid), 32'(1'b0));
        check("rst/tx_req", 32'(tx_req), 32'(1'b0));
        check("rst/rw", 32'(rw), 32'(1'b0));
        check("rst/busy", 32'(busy), 32'(1'b0));
        check("rst/nack", 32'(nack), 32'(1'b0));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle/sda_oen", 32'(sda_oen), 32'(1'b1));

        for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Repeated START: write then read without a STOP in between.
        clear_events();
        tx_q.push_back(8'h96);
        bus_start();
        write_byte(8'h84, -1, a);
        check("rs/addr_w_ack", 32'(a), 32'(1'b1));
        write_byte(8'h11, -1, a);
        check("rs/data_ack", 32'(a), 32'(1'b1));
        check("rs/rw_write", 32'(rw), 32'(1'b0));
        bus_start();
        write_byte(8'h85, -1, a);
        check("rs/addr_r_ack", 32'(a), 32'(1'b1));
        check("rs/rw_read", 32'(rw), 32'(1'b1));
        check("rs/tx_req_on_addr_ack", txr_cnt, 1);
        read_byte(b, 1'b0);
        check("rs/read_data", 32'(b), 32'(8'h96));
        bus_stop();
        repeat (6) @(negedge clk);
        check("rs/nack_count", nack_cnt, 1);
        check("rs/rx_count", rx_q.size(), 1);
        check("rs/rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'(8'h11));

        // Reset while the address ACK is being driven.
        clear_events();
        ab = 8'h85;
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(ab[i], 1'b0);
        check("rstack/ack_driven", 32'(sda_oen), 32'(1'b0));
        check("rstack/busy_before", 32'(busy), 32'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstack/sda_released", 32'(sda_oen), 32'(1'b1));
        check("rstack/busy", 32'(busy), 32'(1'b0));
        check("rstack/rw", 32'(rw), 32'(1'b0));
        check("rstack/rx_byte", 32'(rx_byte), 32'(8'h00));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        m_scl = 1'b1;
        wait_q();
        m_scl = 1'b0;
        wait_q();
        bus_stop();
        run_txn("after_rst", '{8'h84, 1, {8'h00, 8'h00, 8'h00, 8'h5C}, 1'b1, 1, 0, 0});

        // One-clock SDA glitch while SCL is low inside a data byte.
        clear_events();
        bus_start();
        write_byte(8'h84, -1, a);
        write_byte(8'hB6, 3, a);
        check("glitch/ack", 32'(a), 32'(1'b1));
        write_byte(8'h49, 6, a);
        check("glitch/ack2", 32'(a), 32'(1'b1));
        bus_stop();
        repeat (6) @(negedge clk);
        check("glitch/rx_count", rx_q.size(), 2);
        check("glitch/rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'(8'hB6));
        check("glitch/rx1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'(8'h49));

        // Random transfers checked against the model.
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: ab = 8'h84;
                1: ab = 8'h85;
                2: begin
                    a7 = 7'h42;
                    k = int'($urandom_range(0, 6));
                    a7[k] = ~a7[k];
                    ab = {a7, 1'($urandom_range(0, 1))};
                end
                default: ab = 8'($urandom);
            endcase
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
            run_txn($sformatf("rnd%0d", t), model(ab, n, rd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
